// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing one single-ported memory between fetch (IF) and load/store (MEM).
// Optional wait-cycle performance counters are enabled with the ARB_PERF_CNT_EN macro.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_func3,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_if_wait,
   output logic [31:0]       perf_d_wait
`endif
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic       OWN_IF   = 1'b0;
   localparam logic       OWN_D    = 1'b1;
   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

   state_t            state_q, state_d;
   logic [2:0]        lat_cnt_q, lat_cnt_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              store_q, store_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_gnt_s, d_gnt_s;

   // Grants are gated by rst so every output reads zero while reset is asserted.
   always_comb begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
      if (rst && (state_q == IDLE)) begin
         if (if_req && d_req) begin
            if (last_owner_q == OWN_D) begin
               if_gnt_s = 1'b1;
            end else begin
               d_gnt_s = 1'b1;
            end
         end else begin
            if_gnt_s = if_req;
            d_gnt_s  = d_req;
         end
      end else begin
         if_gnt_s = 1'b0;
         d_gnt_s  = 1'b0;
      end
   end

   // Memory command is driven only in the grant cycle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_func3 = 3'b000;
      if (if_gnt_s) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
         mem_func3 = 3'b010;
      end else if (d_gnt_s) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_func3 = d_func3;
      end else begin
         mem_en = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      store_d      = store_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_rvalid_d  = 1'b0;
      d_rvalid_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_gnt_s || d_gnt_s) begin
               state_d      = BUSY;
               lat_cnt_d    = 3'd1;
               owner_d      = d_gnt_s;
               last_owner_d = d_gnt_s;
               store_d      = d_gnt_s & d_we;
            end else begin
               lat_cnt_d = 3'd0;
            end
         end
         BUSY: begin
            // Last latency cycle: mem_rdata is valid now, response pulses next cycle.
            if (lat_cnt_q == LAT_LAST) begin
               state_d   = IDLE;
               lat_cnt_d = 3'd0;
               if (owner_q == OWN_D) begin
                  d_rvalid_d = 1'b1;
                  if (!store_q) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = d_rdata_q;
                  end
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = mem_rdata;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         lat_cnt_q    <= 3'd0;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_IF;
         store_q      <= 1'b0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         if_rdata_q   <= {DATA_W{1'b0}};
         d_rdata_q    <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         store_q      <= store_d;
         if_rvalid_q  <= if_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign if_gnt    = if_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall     = rst & ((if_req & ~if_gnt_s) | (d_req & ~d_gnt_s) | (state_q == BUSY));

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_wait_q, perf_if_wait_d;
   logic [31:0] perf_d_wait_q, perf_d_wait_d;

   // Saturating counts of cycles each requester spends waiting for a grant.
   always_comb begin
      perf_if_wait_d = perf_if_wait_q;
      perf_d_wait_d  = perf_d_wait_q;
      if (if_req && !if_gnt_s && (perf_if_wait_q != 32'hFFFF_FFFF)) begin
         perf_if_wait_d = perf_if_wait_q + 32'd1;
      end else begin
         perf_if_wait_d = perf_if_wait_q;
      end
      if (d_req && !d_gnt_s && (perf_d_wait_q != 32'hFFFF_FFFF)) begin
         perf_d_wait_d = perf_d_wait_q + 32'd1;
      end else begin
         perf_d_wait_d = perf_d_wait_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_if_wait_q <= 32'd0;
         perf_d_wait_q  <= 32'd0;
      end else begin
         perf_if_wait_q <= perf_if_wait_d;
         perf_d_wait_q  <= perf_d_wait_d;
      end
   end

   assign perf_if_wait = perf_if_wait_q;
   assign perf_d_wait  = perf_d_wait_q;
`endif

endmodule
